// File: rtl/icache_nway_axi.sv
// N-way set-associative read-only instruction cache with an AXI-style
// burst refill port. Uncached fetches bypass the arrays as single beats.

// One way of the cache: tag and data storage, both synchronous read.
module icache_way #(
  parameter int SETS       = 128,
  parameter int LINE_WORDS = 8,
  parameter int TAG_W      = 20,
  parameter int IDX_W      = 7,
  parameter int WOFF_W     = 3
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [WOFF_W-1:0] rd_off,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [31:0]       rd_word,
  input  logic              wr_data_en,
  input  logic              wr_tag_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WOFF_W-1:0] wr_off,
  input  logic [31:0]       wr_data,
  input  logic [TAG_W-1:0]  wr_tag
);
  logic [TAG_W-1:0] tag_mem  [SETS];
  logic [31:0]      data_mem [SETS*LINE_WORDS];

  // Array writes from refill; registered reads one cycle after the index.
  always_ff @(posedge clk) begin
    if (wr_tag_en)  tag_mem[wr_idx] <= wr_tag;
    if (wr_data_en) data_mem[{wr_idx, wr_off}] <= wr_data;
    rd_tag  <= tag_mem[rd_idx];
    rd_word <= data_mem[{rd_idx, rd_off}];
  end
endmodule

module icache_nway_axi #(
  parameter int WAYS       = 2,
  parameter int SETS       = 128,
  parameter int LINE_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cache_ena,
  input  logic [31:0] s_araddr,
  input  logic        s_arvalid,
  output logic        s_arready,
  output logic [31:0] s_rdata,
  output logic        s_rvalid,
  input  logic        flush,
  input  logic        inv_all,
  output logic [31:0] m_araddr,
  output logic [7:0]  m_arlen,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic        m_rvalid,
  input  logic        m_rlast,
  output logic        m_rready
);
  localparam int WOFF_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = WOFF_W + 2;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = 32 - IDX_W - OFF_W;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_REQ, REFILL, RESP} state_t;

  state_t              state, state_nxt;
  logic [31:0]         req_addr;
  logic                req_cached;
  logic                cancel;
  logic [WOFF_W-1:0]   beat;
  logic [31:0]         resp_data;
  logic [WAY_W-1:0]    victim, vic_nxt;
  logic                victim_rr, vic_from_rr;
  logic [WAYS-1:0]     valid  [SETS];
  logic [WAY_W-1:0]    rr_ptr [SETS];

  logic [IDX_W-1:0]    req_idx, rd_idx;
  logic [TAG_W-1:0]    req_tag;
  logic [WOFF_W-1:0]   req_off, rd_off;
  logic [WAYS-1:0][TAG_W-1:0] rd_tag;
  logic [WAYS-1:0][31:0]      rd_word;
  logic [WAYS-1:0]     hit;
  logic                hit_any;
  logic [31:0]         hit_word;
  logic                accept, kill, fill_beat, fill_last;

  assign req_idx = req_addr[OFF_W +: IDX_W];
  assign req_tag = req_addr[31 -: TAG_W];
  assign req_off = req_addr[2 +: WOFF_W];

  // Arrays are addressed straight from the request in IDLE so the lookup
  // data is ready the cycle after acceptance.
  assign rd_idx = (state == IDLE) ? s_araddr[OFF_W +: IDX_W] : req_idx;
  assign rd_off = (state == IDLE) ? s_araddr[2 +: WOFF_W]    : req_off;

  assign s_arready = (state == IDLE) && !inv_all && !flush;
  assign accept    = s_arvalid && s_arready;
  assign kill      = cancel || flush;
  assign fill_beat = (state == REFILL) && m_rvalid && req_cached;
  assign fill_last = fill_beat && m_rlast;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_way #(
      .SETS(SETS), .LINE_WORDS(LINE_WORDS), .TAG_W(TAG_W),
      .IDX_W(IDX_W), .WOFF_W(WOFF_W)
    ) u_way (
      .clk        (clk),
      .rd_idx     (rd_idx),
      .rd_off     (rd_off),
      .rd_tag     (rd_tag[w]),
      .rd_word    (rd_word[w]),
      .wr_data_en (fill_beat && (victim == WAY_W'(w))),
      .wr_tag_en  (fill_last && (victim == WAY_W'(w))),
      .wr_idx     (req_idx),
      .wr_off     (beat),
      .wr_data    (m_rdata),
      .wr_tag     (req_tag)
    );
  end

  // Tag compare and hit-way data select.
  always_comb begin
    hit_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit[w] = valid[req_idx][w] && (rd_tag[w] == req_tag);
      if (hit[w]) hit_word = hit_word | rd_word[w];
    end
    hit_any = |hit;
  end

  // Victim: lowest-index invalid way, otherwise the set's round-robin pointer.
  always_comb begin
    vic_nxt     = rr_ptr[req_idx];
    vic_from_rr = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[req_idx][w]) begin
        vic_nxt     = WAY_W'(w);
        vic_from_rr = 1'b0;
      end
    end
    if (WAYS == 1) vic_nxt = '0;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = cache_ena ? LOOKUP : MISS_REQ;
      LOOKUP:   state_nxt = hit_any ? IDLE : MISS_REQ;
      MISS_REQ: if (m_arready) state_nxt = REFILL;
      REFILL:   if (m_rvalid && m_rlast) state_nxt = RESP;
      RESP:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Response and bus outputs; data is forced to zero when not valid.
  always_comb begin
    s_rvalid  = ((state == LOOKUP) && hit_any && !kill) || ((state == RESP) && !kill);
    s_rdata   = '0;
    if (s_rvalid) s_rdata = (state == RESP) ? resp_data : hit_word;
    m_arvalid = (state == MISS_REQ);
    m_araddr  = req_cached ? {req_addr[31:OFF_W], {OFF_W{1'b0}}} : req_addr;
    m_arlen   = req_cached ? 8'(LINE_WORDS - 1) : 8'd0;
    m_rready  = 1'b1;
  end

  // Control registers: state, latched request, cancel flag, refill beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_addr   <= '0;
      req_cached <= 1'b0;
      cancel     <= 1'b0;
      beat       <= '0;
      resp_data  <= '0;
      victim     <= '0;
      victim_rr  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        req_addr   <= s_araddr;
        req_cached <= cache_ena;
      end
      if (state_nxt == IDLE)          cancel <= 1'b0;
      else if (flush && state != IDLE) cancel <= 1'b1;
      if (state == LOOKUP) begin
        victim    <= vic_nxt;
        victim_rr <= vic_from_rr;
      end
      if (state == MISS_REQ && m_arready) beat <= '0;
      if (state == REFILL && m_rvalid) begin
        beat <= beat + 1'b1;
        if (!req_cached || beat == req_off) resp_data <= m_rdata;
      end
    end
  end

  // Valid bits and replacement pointers; invalidate-all clears in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid[s]  <= '0;
        rr_ptr[s] <= '0;
      end
    end else if (state == IDLE && inv_all) begin
      for (int s = 0; s < SETS; s++) valid[s] <= '0;
    end else if (fill_last) begin
      valid[req_idx][victim] <= 1'b1;
      if (victim_rr) rr_ptr[req_idx] <= (WAYS == 1) ? '0 : victim + 1'b1;
    end
  end
endmodule

// File: tb/tb_icache_nway_axi.sv
// Directed bench for icache_nway_axi (4 ways, 128 sets, 8-word lines).
module tb_icache_nway_axi;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cache_ena = 1'b0;
  logic [31:0] s_araddr = '0;
  logic        s_arvalid = 1'b0;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic        s_rvalid;
  logic        flush = 1'b0;
  logic        inv_all = 1'b0;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic        m_arvalid;
  logic        m_arready = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        m_rvalid = 1'b0;
  logic        m_rlast = 1'b0;
  logic        m_rready;

  int checks = 0;
  int errors = 0;

  bit          f_missed;
  int          f_rv_cnt, f_rv_cyc, f_last_cyc, f_beats;
  logic [31:0] f_rdata, f_baddr;
  logic [7:0]  f_blen;
  logic        f_post_arready, f_post_arvalid, f_post_rvalid;

  icache_nway_axi #(.WAYS(4), .SETS(128), .LINE_WORDS(8)) dut (
    .clk(clk), .rst(rst), .cache_ena(cache_ena),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rvalid(s_rvalid), .flush(flush), .inv_all(inv_all),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arvalid(m_arvalid),
    .m_arready(m_arready), .m_rdata(m_rdata), .m_rvalid(m_rvalid),
    .m_rlast(m_rlast), .m_rready(m_rready)
  );

  always #5 clk = ~clk;

  // One fetch with a bus responder; beat i returns base+i. Inputs change and
  // outputs are sampled on the falling edge. flush_beat / rst_beat = -1 disables.
  task automatic fetch(input logic [31:0] addr, input logic ena, input logic [31:0] base,
                       input int ar_delay, input int flush_beat, input int rst_beat);
    int  ph, wcnt, beat;
    bit  done;
    f_missed = 0; f_rv_cnt = 0; f_rv_cyc = -1; f_last_cyc = -1; f_beats = 0;
    f_rdata = '0; f_baddr = '0; f_blen = '0;
    ph = 0; wcnt = 0; beat = 0; done = 0;
    @(negedge clk);
    checks++;
    if (s_arready !== 1'b1) begin errors++; $display("FAIL accept_ready %h: got %b want 1", addr, s_arready); end
    s_araddr = addr; cache_ena = ena; s_arvalid = 1'b1;
    for (int cyc = 1; cyc <= 80 && !done; cyc++) begin
      @(negedge clk);
      s_arvalid = 1'b0;
      if (s_rvalid === 1'b1) begin f_rv_cnt++; f_rdata = s_rdata; f_rv_cyc = cyc; end
      if (m_arvalid === 1'b1) begin f_missed = 1; f_baddr = m_araddr; f_blen = m_arlen; end
      m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; flush = 1'b0; rst = 1'b0;
      if (ph == 3) begin
        f_post_arready = s_arready; f_post_arvalid = m_arvalid; f_post_rvalid = s_rvalid;
        done = 1;
      end else if (ph == 0 && m_arvalid === 1'b1) begin
        if (wcnt == ar_delay) begin m_arready = 1'b1; ph = 1; end
        else wcnt++;
      end else if (ph == 1) begin
        if (beat == rst_beat) begin
          rst = 1'b1; ph = 3;
        end else begin
          m_rvalid = 1'b1; m_rdata = base + beat; m_rlast = (beat == int'(f_blen));
          if (beat == flush_beat) flush = 1'b1;
          if (m_rlast) begin f_last_cyc = cyc; ph = 2; end
          beat++; f_beats = beat;
        end
      end else if (s_arready === 1'b1) begin
        done = 1;
      end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL timeout %h: fetch did not return to idle within 80 cycles", addr);
      m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; flush = 1'b0; rst = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++; if (s_arready !== 1'b1) begin errors++; $display("FAIL reset_arready: got %b want 1", s_arready); end
    checks++; if (s_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", s_rvalid); end
    checks++; if (s_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", s_rdata); end
    checks++; if (m_arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid: got %b want 0", m_arvalid); end
    checks++; if (m_rready !== 1'b1) begin errors++; $display("FAIL reset_rready: got %b want 1", m_rready); end
  endtask

  task automatic test_cold_miss();
    fetch(32'h0000_1004, 1'b1, 32'hA0, 2, -1, -1);
    checks++; if (f_missed !== 1'b1) begin errors++; $display("FAIL cold_missed: got %b want 1", f_missed); end
    checks++; if (f_baddr !== 32'h0000_1000) begin errors++; $display("FAIL cold_araddr: got %h want 00001000", f_baddr); end
    checks++; if (f_blen !== 8'd7) begin errors++; $display("FAIL cold_arlen: got %0d want 7", f_blen); end
    checks++; if (f_beats != 8) begin errors++; $display("FAIL cold_beats: got %0d want 8", f_beats); end
    checks++; if (f_rv_cnt != 1) begin errors++; $display("FAIL cold_rv_count: got %0d want 1", f_rv_cnt); end
    checks++; if (f_rdata !== 32'hA1) begin errors++; $display("FAIL cold_rdata: got %h want a1", f_rdata); end
    checks++; if (f_rv_cyc != f_last_cyc + 1) begin errors++; $display("FAIL cold_latency: rvalid cyc %0d want %0d", f_rv_cyc, f_last_cyc + 1); end
    fetch(32'h0000_101C, 1'b1, 32'hDEAD, 0, -1, -1);
    checks++; if (f_missed !== 1'b0) begin errors++; $display("FAIL rehit_missed: got %b want 0", f_missed); end
    checks++; if (f_rv_cyc != 1) begin errors++; $display("FAIL rehit_latency: got %0d want 1", f_rv_cyc); end
    checks++; if (f_rdata !== 32'hA7) begin errors++; $display("FAIL rehit_rdata: got %h want a7", f_rdata); end
  endtask

  task automatic test_victim();
    int t;
    logic [31:0] a;
    for (t = 1; t <= 5; t++) begin
      a = (32'(t) << 12) | 32'h60;
      fetch(a, 1'b1, 32'(t) << 8, 0, -1, -1);
      checks++; if (f_missed !== 1'b1 || f_rdata !== (32'(t) << 8)) begin errors++; $display("FAIL victim_fill%0d: missed %b data %h want 1 %h", t, f_missed, f_rdata, 32'(t) << 8); end
    end
    // way0 was overwritten by tag 5: tag 1 misses and, with the pointer at 1, evicts tag 2
    fetch(32'h0000_1060, 1'b1, 32'h100, 0, -1, -1);
    checks++; if (f_missed !== 1'b1) begin errors++; $display("FAIL victim_tag1_evicted: missed %b want 1", f_missed); end
    for (t = 3; t <= 5; t++) begin
      a = (32'(t) << 12) | 32'h60;
      fetch(a, 1'b1, 32'hFFFF, 0, -1, -1);
      checks++; if (f_missed !== 1'b0 || f_rdata !== (32'(t) << 8)) begin errors++; $display("FAIL victim_hold%0d: missed %b data %h want 0 %h", t, f_missed, f_rdata, 32'(t) << 8); end
    end
    fetch(32'h0000_1060, 1'b1, 32'hFFFF, 0, -1, -1);
    checks++; if (f_missed !== 1'b0 || f_rdata !== 32'h100) begin errors++; $display("FAIL victim_tag1_hit: missed %b data %h want 0 00000100", f_missed, f_rdata); end
    fetch(32'h0000_2060, 1'b1, 32'h200, 0, -1, -1);
    checks++; if (f_missed !== 1'b1) begin errors++; $display("FAIL victim_rr_way1: missed %b want 1", f_missed); end
  endtask

  task automatic test_uncached();
    fetch(32'hBFC0_0008, 1'b0, 32'h1234_5678, 1, -1, -1);
    checks++; if (f_blen !== 8'd0) begin errors++; $display("FAIL unc_arlen: got %0d want 0", f_blen); end
    checks++; if (f_baddr !== 32'hBFC0_0008) begin errors++; $display("FAIL unc_araddr: got %h want bfc00008", f_baddr); end
    checks++; if (f_beats != 1) begin errors++; $display("FAIL unc_beats: got %0d want 1", f_beats); end
    checks++; if (f_rdata !== 32'h1234_5678 || f_rv_cnt != 1) begin errors++; $display("FAIL unc_rdata: got %h x%0d want 12345678 x1", f_rdata, f_rv_cnt); end
    fetch(32'hBFC0_0008, 1'b1, 32'h5500_0000, 0, -1, -1);
    checks++; if (f_missed !== 1'b1 || f_baddr !== 32'hBFC0_0000) begin errors++; $display("FAIL unc_then_cached: missed %b addr %h want 1 bfc00000", f_missed, f_baddr); end
    checks++; if (f_rdata !== 32'h5500_0002) begin errors++; $display("FAIL unc_then_cached_data: got %h want 55000002", f_rdata); end
  endtask

  task automatic test_flush_refill();
    fetch(32'h0000_5008, 1'b1, 32'hC0, 1, 3, -1);
    checks++; if (f_missed !== 1'b1) begin errors++; $display("FAIL flush_missed: got %b want 1", f_missed); end
    checks++; if (f_beats != 8) begin errors++; $display("FAIL flush_beats: got %0d want 8", f_beats); end
    checks++; if (f_rv_cnt != 0) begin errors++; $display("FAIL flush_rvalid: got %0d pulses want 0", f_rv_cnt); end
    fetch(32'h0000_5008, 1'b1, 32'hFFFF, 0, -1, -1);
    checks++; if (f_missed !== 1'b0 || f_rdata !== 32'hC2) begin errors++; $display("FAIL flush_line_installed: missed %b data %h want 0 c2", f_missed, f_rdata); end
  endtask

  task automatic test_inv_all();
    logic [31:0] a;
    for (int k = 0; k < 4; k++) fetch(32'h0000_8000 + 32'(k) * 32'h20, 1'b1, 32'hD0 + 32'(k) * 32'h10, 0, -1, -1);
    for (int k = 0; k < 4; k++) begin
      a = 32'h0000_8000 + 32'(k) * 32'h20;
      fetch(a, 1'b1, 32'hFFFF, 0, -1, -1);
      checks++; if (f_missed !== 1'b0 || f_rdata !== 32'hD0 + 32'(k) * 32'h10) begin errors++; $display("FAIL inv_prefill_hit%0d: missed %b data %h", k, f_missed, f_rdata); end
    end
    @(negedge clk);
    inv_all = 1'b1; s_arvalid = 1'b1; s_araddr = 32'h0000_8000; cache_ena = 1'b1;
    #1;
    checks++; if (s_arready !== 1'b0) begin errors++; $display("FAIL inv_arready: got %b want 0", s_arready); end
    @(negedge clk);
    inv_all = 1'b0; s_arvalid = 1'b0;
    #1;
    checks++; if (s_arready !== 1'b1 || s_rvalid !== 1'b0) begin errors++; $display("FAIL inv_req_ignored: arready %b rvalid %b want 1 0", s_arready, s_rvalid); end
    for (int k = 0; k < 4; k++) begin
      a = 32'h0000_8000 + 32'(k) * 32'h20;
      fetch(a, 1'b1, 32'hE0, 0, -1, -1);
      checks++; if (f_missed !== 1'b1) begin errors++; $display("FAIL inv_miss%0d: missed %b want 1", k, f_missed); end
    end
  endtask

  task automatic test_reset_mid_refill();
    fetch(32'h0000_3000, 1'b1, 32'hE0, 0, -1, 4);
    checks++; if (f_beats != 4) begin errors++; $display("FAIL rstmid_beats: got %0d want 4", f_beats); end
    checks++; if (f_post_arready !== 1'b1) begin errors++; $display("FAIL rstmid_idle: arready %b want 1", f_post_arready); end
    checks++; if (f_post_arvalid !== 1'b0 || f_post_rvalid !== 1'b0) begin errors++; $display("FAIL rstmid_outputs: arvalid %b rvalid %b want 0 0", f_post_arvalid, f_post_rvalid); end
    fetch(32'h0000_3000, 1'b1, 32'hF0, 0, -1, -1);
    checks++; if (f_missed !== 1'b1 || f_rdata !== 32'hF0) begin errors++; $display("FAIL rstmid_line_invalid: missed %b data %h want 1 f0", f_missed, f_rdata); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_victim();
    test_uncached();
    test_flush_refill();
    test_inv_all();
    test_reset_mid_refill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/icache_nway_axi.md
Name: icache_nway_axi

Overview:
- Parametrised N-way set-associative, read-only instruction cache between the CPU fetch stage (slave side) and an AXI-style read channel (master side).
- Generalises the fixed 2-way/128-set/8-word fetch cache in four ways:
  - configurable ways, sets and line size;
  - first-invalid-then-round-robin victim selection;
  - explicit request handshake;
  - single-cycle invalidate-all with a flush-safe bus drain.
- Uncached fetches bypass the arrays with single-beat reads.

Parameters:
- WAYS, 2: associativity; power of 2, 1..8.
- SETS, 128: sets per way; power of 2, 16..512.
- LINE_WORDS, 8: 32-bit words per line; power of 2, 2..16.
- Derived: OFF_W = log2(LINE_WORDS)+2, IDX_W = log2(SETS), TAG_W = 32-IDX_W-OFF_W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- cache_ena  in  1  request is cacheable; sampled with the request
- s_araddr  in  32  fetch address, word aligned
- s_arvalid  in  1  fetch request valid
- s_arready  out  1  request accepted this cycle
- s_rdata  out  32  fetch data
- s_rvalid  out  1  fetch data valid; one-cycle pulse
- flush  in  1  cancel the outstanding response (pipeline redirect)
- inv_all  in  1  invalidate every line
- m_araddr  out  32  bus read address
- m_arlen  out  8  beats-1
- m_arvalid  out  1  bus address valid
- m_arready  in  1  bus address accepted
- m_rdata  in  32  bus read data
- m_rvalid  in  1  bus beat valid
- m_rlast  in  1  last beat
- m_rready  out  1  constant 1

Behaviour:
- Reset:
  - state IDLE; all valid bits 0; all round-robin pointers 0;
  - s_rvalid=0, s_rdata=0, m_arvalid=0, s_arready=1 after reset;
  - tag/data array contents are don't-care.
  - Reset mid-burst abandons the burst; the bus is reset together with the cache.
- Arrays:
  - tag and data storage is per way, synchronous read, one cycle latency.
  - Read index is taken from s_araddr in IDLE, otherwise from the latched address.
- s_arready = (state==IDLE) && !inv_all && !flush.
- Handshake: a request is accepted when s_arvalid && s_arready; the address and cache_ena are latched.
- IDLE:
  - inv_all=1: clear all valid bits this cycle; stay in IDLE. inv_all has priority over any request.
  - Accepted cacheable request: go to LOOKUP.
  - Accepted uncached request: go to MISS_REQ with m_araddr = exact address and m_arlen=0.
- LOOKUP:
  - hit[w] = valid[w][idx] && tag[w]==tag_req; at most one way hits.
  - Hit: s_rvalid=1 and s_rdata = word[offset] of the hit way in this cycle, i.e. latency 1 after acceptance; return to IDLE.
  - Miss:
    - victim = lowest-index invalid way, else rr_ptr[idx];
    - go to MISS_REQ with m_araddr = line base (offset bits zero) and m_arlen = LINE_WORDS-1.
- MISS_REQ:
  - m_arvalid=1 and held until m_arready; address and len stay stable.
  - On handshake go to REFILL with beat counter 0.
- REFILL:
  - Each m_rvalid beat writes m_rdata to victim data[beat] and increments beat.
  - The beat whose count equals the requested word offset is captured into the response register.
  - On the beat with m_rlast:
    - write victim tag, set its valid bit;
    - rr_ptr[idx] = victim+1 mod WAYS, updated only when the victim came from the pointer;
    - go to RESP.
  - Uncached: the single beat is captured; nothing is written to the arrays or tag state.
- RESP: s_rvalid=1 with the captured word for one cycle unless cancelled; then IDLE.
- Flush:
  - flush=1 in LOOKUP, MISS_REQ, REFILL or RESP sets a cancel flag.
  - The bus transaction always completes; m_arvalid is never withdrawn and the refill still installs the line.
  - While cancel is set, s_rvalid is suppressed.
  - The flag is cleared on return to IDLE.
  - flush in the same cycle as a LOOKUP hit suppresses that hit's s_rvalid.
- inv_all outside IDLE: ignored. The CPU holds it until s_arready would be high.
- m_rlast before LINE_WORDS beats (protocol error): treated as end of line; the line is still marked valid. This is not required to be correct data.
- WAYS=1: victim is always way 0; rr_ptr is unused.
- s_rdata = 0 whenever s_rvalid=0.

Test Plan:
- Cold miss, cacheable:
  - stimulus: fetch 0x0000_1004; bus returns 8 beats 0xA0..0xA7 with m_arready after 2 cycles.
  - response: m_araddr=0x0000_1000, m_arlen=7; s_rvalid pulse with 0xA1 one cycle after rlast; re-fetching 0x0000_101C hits with 0xA7 at latency 1.
- Victim selection, WAYS=4:
  - stimulus: miss five distinct tags mapping to index 3.
  - response: fills go to ways 0,1,2,3 (invalid-first), then way 0 via rr_ptr; rr_ptr[3]=1 afterwards; the first tag now misses.
- Uncached:
  - stimulus: cache_ena=0, address 0xBFC0_0008, bus returns 0x1234_5678.
  - response: m_arlen=0, m_araddr=0xBFC0_0008; s_rdata=0x1234_5678; a subsequent cached fetch of the same address misses.
- Flush during refill:
  - stimulus: assert flush at beat 3 of a miss.
  - response: all 8 beats are consumed and no s_rvalid is produced; a subsequent fetch of that line hits.
- inv_all:
  - stimulus: after filling 4 lines, pulse inv_all in IDLE.
  - response: s_arready=0 that cycle; all 4 addresses then miss.
- Reset mid-REFILL:
  - stimulus: rst at beat 4.
  - response: next cycle IDLE, m_arvalid=0, s_rvalid=0; the line is not valid.
